wta_disparity_select: RTL and testbench

//   Winner-take-all consumer of the SAD compare path. Takes a stream of unsigned SAD costs,
//   one per candidate disparity 0..NUM_DISP-1 for a single pixel, and tracks the running

---
 rtl/wta_pkg.sv | 17 +
 rtl/wta_disparity_select_sad_lt.sv | 15 +
 rtl/wta_disparity_select.sv | 127 ++++++++++++
 tb/tb_wta_disparity_select.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wta_pkg.sv
// Shared types and default sizes for the winner-take-all disparity selector.
package wta_pkg;

  localparam int SAD_WIDTH  = 16;
  localparam int NUM_DISP   = 64;
  localparam int DISP_WIDTH = $clog2(NUM_DISP);

  typedef logic [SAD_WIDTH-1:0]  sad_t;
  typedef logic [DISP_WIDTH-1:0] disp_t;

  // ACCUM: collecting costs of the current pixel; DONE: result held for downstream.
  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

endpackage

// File: rtl/wta_disparity_select_sad_lt.sv
// Strict unsigned less-than on two SAD costs; feeds the running-minimum update mux.
module sad_lt
  import wta_pkg::*;
#(
  parameter int W = SAD_WIDTH
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         lt
);

  // Both operands are plain unsigned vectors, so all-ones compares as the largest cost.
  assign lt = (a < b);

endmodule

// File: rtl/wta_disparity_select.sv
// Winner-take-all disparity selector: tracks the minimum SAD over NUM_DISP candidate
// disparities per pixel and hands the winning index and cost downstream over valid/ready.
module wta_disparity_select
  import wta_pkg::*;
#(
  parameter int SAD_WIDTH  = wta_pkg::SAD_WIDTH,
  parameter int NUM_DISP   = wta_pkg::NUM_DISP,
  parameter int DISP_WIDTH = $clog2(NUM_DISP)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [SAD_WIDTH-1:0]  sad_in,
  input  logic                  sad_valid_in,
  input  logic                  sad_last_in,
  output logic                  sad_ready_out,
  output logic [DISP_WIDTH-1:0] disp_out,
  output logic [SAD_WIDTH-1:0]  min_sad_out,
  output logic                  disp_valid_out,
  input  logic                  disp_ready_in,
  output logic                  proto_err_out
);

  localparam logic [DISP_WIDTH-1:0] LAST_IDX = DISP_WIDTH'(NUM_DISP - 1);

  state_t                  state_p0;
  state_t                  state_nxt;
  logic [DISP_WIDTH-1:0]   cnt_p0;
  logic [DISP_WIDTH-1:0]   idx_p0;
  logic [DISP_WIDTH-1:0]   idx_nxt;
  logic [SAD_WIDTH-1:0]    min_p0;
  logic [SAD_WIDTH-1:0]    min_nxt;
  logic                    accept;
  logic                    cnt_first;
  logic                    cnt_last;
  logic                    lt;
  logic                    take;

  // The state register doubles as the result-valid flag: DONE means a result is held.
  assign disp_valid_out = (state_p0 == DONE);

  // Single result slot: a new beat may enter only if the slot is empty or draining now.
  assign sad_ready_out = !disp_valid_out || disp_ready_in;
  assign accept        = sad_valid_in && sad_ready_out;

  assign cnt_first = (cnt_p0 == '0);
  assign cnt_last  = (cnt_p0 == LAST_IDX);

  sad_lt #(
    .W (SAD_WIDTH)
  ) u_sad_lt (
    .a  (sad_in),
    .b  (min_p0),
    .lt (lt)
  );

  // Candidate running minimum: disparity 0 always seeds it; later ones replace it only
  // when strictly cheaper, so ties keep the lower disparity.
  always_comb begin
    take    = cnt_first || lt;
    min_nxt = min_p0;
    idx_nxt = idx_p0;
    if (take) begin
      min_nxt = sad_in;
      idx_nxt = cnt_p0;
    end
  end

  // Next-state: finish on the internally counted final beat; release on handshake, but a
  // final beat landing in the same cycle as the handshake keeps the slot full.
  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      ACCUM: begin
        if (accept && cnt_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (disp_ready_in) begin
          state_nxt = (accept && cnt_last) ? DONE : ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_p0 <= ACCUM;
    end else begin
      state_p0 <= state_nxt;
    end
  end

  // Disparity counter, running min/index and the registered result; reset drops any
  // partial pixel so the next beat is disparity 0.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      cnt_p0      <= '0;
      min_p0      <= '0;
      idx_p0      <= '0;
      disp_out    <= '0;
      min_sad_out <= '0;
    end else if (accept) begin
      min_p0 <= min_nxt;
      idx_p0 <= idx_nxt;
      if (cnt_last) begin
        cnt_p0      <= '0;
        disp_out    <= idx_nxt;
        min_sad_out <= min_nxt;
      end else begin
        cnt_p0 <= cnt_p0 + DISP_WIDTH'(1);
      end
    end
  end

  // Sticky framing error: sender's last flag disagreed with the internal count.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      proto_err_out <= 1'b0;
    end else if (accept && (sad_last_in != cnt_last)) begin
      proto_err_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wta_disparity_select.sv
// Bench for wta_disparity_select with NUM_DISP=4: directed cases plus random traffic,
// checked by a queue-based scoreboard fed from a per-pixel reference model.
module tb_wta_disparity_select;

  localparam int SW = 16;
  localparam int ND = 4;
  localparam int DW = 2;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [SW-1:0] sad_in;
  logic          sad_valid_in;
  logic          sad_last_in;
  logic          sad_ready_out;
  logic [DW-1:0] disp_out;
  logic [SW-1:0] min_sad_out;
  logic          disp_valid_out;
  logic          disp_ready_in;
  logic          proto_err_out;

  always #5 clk_in = ~clk_in;

  wta_disparity_select #(
    .SAD_WIDTH  (SW),
    .NUM_DISP   (ND),
    .DISP_WIDTH (DW)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .sad_in         (sad_in),
    .sad_valid_in   (sad_valid_in),
    .sad_last_in    (sad_last_in),
    .sad_ready_out  (sad_ready_out),
    .disp_out       (disp_out),
    .min_sad_out    (min_sad_out),
    .disp_valid_out (disp_valid_out),
    .disp_ready_in  (disp_ready_in),
    .proto_err_out  (proto_err_out)
  );

  int total = 0;
  int bad   = 0;
  int exp_d[$];
  int exp_m[$];
  int pix[$];
  int rdy_mode = 0;   // 0: always ready, 1: never ready, 2: random

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: once a pixel's NUM_DISP costs are in, the winner is the smallest cost
  // and, among equal costs, the first disparity that carries it.
  function automatic void model_accept(input int c);
    int mn;
    pix.push_back(c);
    if (pix.size() == ND) begin
      mn = pix[0];
      foreach (pix[i]) if (pix[i] < mn) mn = pix[i];
      for (int i = 0; i < ND; i++) begin
        if (pix[i] == mn) begin
          exp_d.push_back(i);
          break;
        end
      end
      exp_m.push_back(mn);
      pix.delete();
    end
  endfunction

  task automatic drive_rdy();
    case (rdy_mode)
      0:       disp_ready_in = 1'b1;
      1:       disp_ready_in = 1'b0;
      default: disp_ready_in = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic send_beat(input int c, input bit last);
    int  n   = 0;
    bit  acc = 0;
    while (!acc) begin
      @(negedge clk_in);
      drive_rdy();
      sad_in       = c[SW-1:0];
      sad_valid_in = 1'b1;
      sad_last_in  = last;
      #1;
      if (sad_ready_out) begin
        @(posedge clk_in);
        acc = 1;
        model_accept(c);
        #1;
        sad_valid_in = 1'b0;
        sad_last_in  = 1'b0;
      end else begin
        n++;
        if (n >= 50) begin
          chk("beat_accept_timeout", 0, 1);
          sad_valid_in = 1'b0;
          acc = 1;
        end
      end
    end
  endtask

  task automatic send_px(input int a, input int b, input int c, input int d);
    send_beat(a, 1'b0);
    send_beat(b, 1'b0);
    send_beat(c, 1'b0);
    send_beat(d, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_in);
      drive_rdy();
      sad_valid_in = 1'b0;
      sad_last_in  = 1'b0;
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (cycles) begin
      @(negedge clk_in);
      sad_in        = SW'($urandom);
      sad_valid_in  = 1'($urandom_range(0, 1));
      sad_last_in   = 1'($urandom_range(0, 1));
      disp_ready_in = 1'($urandom_range(0, 1));
    end
    pix.delete();
    @(posedge clk_in);
    #1;
    chk("rst_valid", disp_valid_out, 0);
    chk("rst_disp", disp_out, 0);
    chk("rst_min", min_sad_out, 0);
    chk("rst_proto", proto_err_out, 0);
    @(negedge clk_in);
    rst_in       = 1'b1;
    sad_valid_in = 1'b0;
    sad_last_in  = 1'b0;
    drive_rdy();
    #1;
    chk("rst_ready_after", sad_ready_out, 1);
  endtask

  // Monitor: while a result is offered it must match the oldest expectation; it is
  // consumed when downstream is ready, and under backpressure the block must refuse beats.
  initial begin
    forever begin
      @(negedge clk_in);
      #2;
      if (rst_in === 1'b1 && disp_valid_out) begin
        if (exp_d.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else if (!disp_ready_in) begin
          chk("hold_disp", disp_out, exp_d[0]);
          chk("hold_min", min_sad_out, exp_m[0]);
          chk("hold_sad_ready", sad_ready_out, 0);
        end else begin
          chk("disp", disp_out, exp_d.pop_front());
          chk("min_sad", min_sad_out, exp_m.pop_front());
        end
      end
    end
  end

  initial begin
    int n;
    int c;
    rst_in        = 1'b0;
    sad_in        = '0;
    sad_valid_in  = 1'b0;
    sad_last_in   = 1'b0;
    disp_ready_in = 1'b1;

    // Reset held with random inputs.
    do_reset(3);

    // Basic pixel with latency check.
    rdy_mode = 0;
    send_beat(9, 1'b0);
    send_beat(3, 1'b0);
    send_beat(7, 1'b0);
    chk("latency_before", disp_valid_out, 0);
    send_beat(5, 1'b1);
    chk("latency_after", disp_valid_out, 1);
    idle(2);

    // Ties and all-ones costs.
    send_px(5, 2, 2, 8);
    idle(2);
    send_px(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    idle(2);

    // Backpressure, then a new pixel whose first beat meets the handshake.
    rdy_mode = 1;
    send_px(1, 2, 3, 4);
    idle(5);
    chk("bp_valid_held", disp_valid_out, 1);
    rdy_mode = 0;
    send_px(4, 4, 1, 6);
    idle(2);
    chk("no_proto_yet", proto_err_out, 0);

    // Misplaced last flag on beat 2 of 4.
    send_beat(3, 1'b0);
    send_beat(8, 1'b1);
    chk("proto_set", proto_err_out, 1);
    send_beat(1, 1'b0);
    chk("no_early_result", disp_valid_out, 0);
    send_beat(2, 1'b1);
    chk("proto_result_valid", disp_valid_out, 1);
    idle(3);
    chk("proto_sticky", proto_err_out, 1);

    // Reset mid-pixel discards the partial minimum.
    send_beat(0, 1'b0);
    send_beat(0, 1'b0);
    do_reset(2);
    send_px(6, 1, 9, 9);
    idle(3);

    // Random traffic with random downstream readiness.
    rdy_mode = 2;
    for (int p = 0; p < 150; p++) begin
      for (int b = 0; b < ND; b++) begin
        case ($urandom_range(0, 3))
          0:       c = int'($urandom_range(0, 3));
          1:       c = 16'hFFFF;
          default: c = int'($urandom_range(0, 65535));
        endcase
        send_beat(c, b == ND - 1);
        if ($urandom_range(0, 7) == 0) idle(int'($urandom_range(1, 3)));
      end
    end

    // Drain.
    rdy_mode = 0;
    n = 0;
    while (exp_d.size() > 0 && n < 100) begin
      idle(1);
      n++;
    end
    idle(2);
    chk("drain_left", exp_d.size(), 0);
    chk("final_proto_clean", proto_err_out, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
